// File: rtl/goertzel_tone_gen.sv
// ---------------------------------------------------------------------------
// goertzel_tone_gen
//   Burst sine-tone synthesizer. The Goertzel resonator
//       y[n] = BIN_COEFF * y[n-1] / 2^23 - y[n-2]
//   is run as an oscillator. It emits FRAME_LEN signed 24-bit samples per
//   burst, one for each advance_in strobe. The detector bank uses the same
//   BIN_COEFF encoding, so the generated tone falls into the matching bin.
//
// Parameters
//   BIN_COEFF    unsigned 2*cos(w)*2^23 (detector bin_coeff encoding)
//   SIN_SEED     signed A*sin(w); sets the tone amplitude A
//   FRAME_LEN    samples per burst, 2..1024
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   asynchronous, active-low reset
//   start         in   1   one-cycle pulse that begins a burst (IDLE only)
//   stop          in   1   aborts a running burst; wins over start in IDLE
//   advance_in    in   1   sample-rate strobe, one output sample per strobe
//   output_sig    out  24  saturated signed sample, valid while advance=1
//   advance       out  1   one-cycle strobe marking a new output_sig
//   busy          out  1   high while a burst is running
//   done          out  1   one-cycle pulse after a burst completes normally
//   sample_index  out  10  index of the sample currently on output_sig
// ---------------------------------------------------------------------------
module goertzel_tone_gen #(
    parameter logic        [31:0] BIN_COEFF = 32'd0,
    parameter logic signed [23:0] SIN_SEED  = 24'sd0,
    parameter int                 FRAME_LEN = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               advance_in,
    output logic signed [23:0] output_sig,
    output logic               advance,
    output logic               busy,
    output logic               done,
    output logic        [9:0]  sample_index
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The coefficient is zero-extended and the seed is sign-extended to 64 bits.
    localparam logic signed [63:0] COEFF_64 = {32'd0, BIN_COEFF};
    localparam logic signed [63:0] SEED_64  = {{40{SIN_SEED[23]}}, SIN_SEED};
    localparam logic        [9:0]  LAST_IDX = 10'(FRAME_LEN - 1);

    // Clamp a 64-bit value to the signed 24-bit output range.
    function automatic logic signed [23:0] sat24(input logic signed [63:0] v);
        logic signed [23:0] r;
        if (v > 64'sh0000_0000_007F_FFFF) begin
            r = 24'sh7F_FFFF;
        end else if (v < 64'shFFFF_FFFF_FF80_0000) begin
            r = 24'sh80_0000;
        end else begin
            r = v[23:0];
        end
        return r;
    endfunction

    state_t              state_r;
    state_t              next_state_s;
    logic signed [63:0]  cur_r;
    logic signed [63:0]  prev_r;
    logic        [9:0]   counter_r;
    logic                done_pend_r;
    logic signed [23:0]  output_sig_r;
    logic                advance_r;
    logic                busy_r;
    logic                done_r;
    logic        [9:0]   sample_index_r;

    logic                load_s;
    logic                step_s;
    logic                last_s;
    logic                abort_s;
    logic signed [63:0]  prod_s;
    logic signed [63:0]  bias_s;
    logic signed [63:0]  quot_s;
    logic signed [63:0]  next_cur_s;

    // Resonator step. An arithmetic shift rounds toward minus infinity, so
    // negative products get a 2^23-1 bias to truncate toward zero instead.
    always_comb begin
        prod_s = COEFF_64 * cur_r;
        if (prod_s[63]) begin
            bias_s = 64'sd8388607;
        end else begin
            bias_s = 64'sd0;
        end
        quot_s     = (prod_s + bias_s) >>> 23;
        next_cur_s = quot_s - prev_r;
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // A strobe coinciding with start is not consumed.
                if (start && !stop) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                // Stop has priority; a strobe in the same cycle is dropped.
                if (stop) begin
                    next_state_s = IDLE;
                    abort_s      = 1'b1;
                end else if (advance_in) begin
                    step_s = 1'b1;
                    if (counter_r == LAST_IDX) begin
                        next_state_s = IDLE;
                        last_s       = 1'b1;
                    end else begin
                        next_state_s = RUN;
                    end
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Oscillator datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_r          <= 64'sd0;
            prev_r         <= 64'sd0;
            counter_r      <= 10'd0;
            done_pend_r    <= 1'b0;
            output_sig_r   <= 24'sd0;
            advance_r      <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            sample_index_r <= 10'd0;
        end else begin
            advance_r   <= step_s;
            // done trails the final advance by one cycle, so they never overlap.
            done_pend_r <= last_s;
            done_r      <= done_pend_r;
            if (load_s) begin
                // Seeding prev with -SIN_SEED makes the sequence 0, SIN_SEED, ...
                cur_r     <= 64'sd0;
                prev_r    <= -SEED_64;
                counter_r <= 10'd0;
                busy_r    <= 1'b1;
            end else if (abort_s) begin
                busy_r       <= 1'b0;
                output_sig_r <= 24'sd0;
            end else if (step_s) begin
                output_sig_r   <= sat24(cur_r);
                sample_index_r <= counter_r;
                cur_r          <= next_cur_s;
                prev_r         <= cur_r;
                counter_r      <= counter_r + 10'd1;
                busy_r         <= !last_s;
            end
        end
    end

    assign output_sig   = output_sig_r;
    assign advance      = advance_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_index = sample_index_r;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
module tb_goertzel_tone_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Instance 2: BIN_COEFF=0, SIN_SEED=1000, FRAME_LEN=8
    logic st2, sp2, a2, adv2, busy2, done2;
    logic signed [23:0] o2;
    logic [9:0] idx2;
    // Instance 3: w=0 ramp
    logic st3, sp3, a3, adv3, busy3, done3;
    logic signed [23:0] o3;
    logic [9:0] idx3;
    // Instance 4: w=pi/8, full-scale tone
    logic st4, sp4, a4, adv4, busy4, done4;
    logic signed [23:0] o4;
    logic [9:0] idx4;

    goertzel_tone_gen #(.BIN_COEFF(32'd0), .SIN_SEED(24'sd1000), .FRAME_LEN(8)) u2 (
        .clk(clk), .reset(reset), .start(st2), .stop(sp2), .advance_in(a2),
        .output_sig(o2), .advance(adv2), .busy(busy2), .done(done2), .sample_index(idx2));
    goertzel_tone_gen #(.BIN_COEFF(32'd16777216), .SIN_SEED(24'sd100000), .FRAME_LEN(100)) u3 (
        .clk(clk), .reset(reset), .start(st3), .stop(sp3), .advance_in(a3),
        .output_sig(o3), .advance(adv3), .busy(busy3), .done(done3), .sample_index(idx3));
    goertzel_tone_gen #(.BIN_COEFF(32'd15500127), .SIN_SEED(24'sd3210181), .FRAME_LEN(1024)) u4 (
        .clk(clk), .reset(reset), .start(st4), .stop(sp4), .advance_in(a4),
        .output_sig(o4), .advance(adv4), .busy(busy4), .done(done4), .sample_index(idx4));

    int tests = 0;
    int fails = 0;
    int adv_cnt2 = 0;
    int done_cnt2 = 0;
    int overlap_cnt = 0;

    always @(posedge clk) begin
        if (adv2) adv_cnt2 <= adv_cnt2 + 1;
        if (done2) done_cnt2 <= done_cnt2 + 1;
        if ((adv2 && done2) || (adv3 && done3) || (adv4 && done4)) overlap_cnt <= overlap_cnt + 1;
    end

    typedef struct {
        logic signed [23:0] out;
        logic [9:0]         idx;
    } vec_t;
    vec_t tbl[8];

    longint samp4[1024];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe2();
        a2 = 1'b1;
        tick();
        a2 = 1'b0;
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607) return 64'sd8388607;
        else if (v < -64'sd8388608) return -64'sd8388608;
        else return v;
    endfunction

    function automatic real gpower(input int k);
        real coef, s0, s1, s2;
        coef = 2.0 * $cos(2.0 * 3.14159265358979 * k / 1024.0);
        s1 = 0.0;
        s2 = 0.0;
        for (int n = 0; n < 1024; n++) begin
            s0 = real'(samp4[n]) + coef * s1 - s2;
            s2 = s1;
            s1 = s0;
        end
        return s1 * s1 + s2 * s2 - coef * s1 * s2;
    endfunction

    initial begin
        int adv_base, done_base;
        longint c, p, q, e, diff, peak;
        real pk, pl, ph;

        tbl[0] = '{24'sd0, 10'd0};     tbl[1] = '{24'sd1000, 10'd1};
        tbl[2] = '{24'sd0, 10'd2};     tbl[3] = '{-24'sd1000, 10'd3};
        tbl[4] = '{24'sd0, 10'd4};     tbl[5] = '{24'sd1000, 10'd5};
        tbl[6] = '{24'sd0, 10'd6};     tbl[7] = '{-24'sd1000, 10'd7};

        {st2, sp2, a2, st3, sp3, a3, st4, sp4, a4} = 9'd0;
        reset = 1'b0;
        tick(); tick();
        check("rst_out", longint'(o2), 0);
        check("rst_adv", adv2, 0);
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_idx", idx2, 0);
        reset = 1'b1;
        tick();

        // Test 2: table-driven burst, strobe every 4 clocks
        st2 = 1'b1; tick(); st2 = 1'b0;
        check("t2_busy_start", busy2, 1);
        for (int k = 0; k < 8; k++) begin
            tick(); tick(); tick();
            if (k == 0) check("t2_no_early_adv", adv2, 0);
            strobe2();
            check($sformatf("t2_adv[%0d]", k), adv2, 1);
            check($sformatf("t2_out[%0d]", k), longint'(o2), longint'(tbl[k].out));
            check($sformatf("t2_idx[%0d]", k), idx2, tbl[k].idx);
            check($sformatf("t2_busy[%0d]", k), busy2, (k == 7) ? 0 : 1);
            check($sformatf("t2_done_early[%0d]", k), done2, 0);
        end
        tick();
        check("t2_done", done2, 1);
        check("t2_adv_off", adv2, 0);
        check("t2_hold", longint'(o2), -1000);
        tick();
        check("t2_done_pulse", done2, 0);

        // Test 1: reset mid-burst at sample 5
        done_base = done_cnt2;
        st2 = 1'b1; tick(); st2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            strobe2();
        end
        check("t1_pre_idx", idx2, 5);
        check("t1_pre_out", longint'(o2), 1000);
        tick();
        #2 reset = 1'b0;
        #1;
        check("t1_async_out", longint'(o2), 0);
        check("t1_async_idx", idx2, 0);
        check("t1_async_busy", busy2, 0);
        #2 reset = 1'b1;
        tick(); tick(); tick();
        check("t1_no_done", done_cnt2 - done_base, 0);
        st2 = 1'b1; tick(); st2 = 1'b0;
        strobe2();
        check("t1_restart_idx0", idx2, 0);
        check("t1_restart_out0", longint'(o2), 0);
        tick();
        strobe2();
        check("t1_restart_idx1", idx2, 1);
        check("t1_restart_out1", longint'(o2), 1000);
        sp2 = 1'b1; tick(); sp2 = 1'b0;
        tick();

        // Test 5: start with coincident strobe, stop after 3 samples
        adv_base = adv_cnt2;
        done_base = done_cnt2;
        st2 = 1'b1; a2 = 1'b1; tick(); st2 = 1'b0; a2 = 1'b0;
        check("t5_strobe_not_consumed", adv2, 0);
        check("t5_busy", busy2, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            strobe2();
            check($sformatf("t5_idx[%0d]", k), idx2, k);
            check($sformatf("t5_out[%0d]", k), longint'(o2), longint'(tbl[k].out));
        end
        sp2 = 1'b1; a2 = 1'b1; tick(); sp2 = 1'b0; a2 = 1'b0;
        check("t5_stop_adv", adv2, 0);
        check("t5_stop_out", longint'(o2), 0);
        check("t5_stop_busy", busy2, 0);
        tick(); tick(); tick();
        check("t5_count", adv_cnt2 - adv_base, 3);
        check("t5_no_done", done_cnt2 - done_base, 0);

        // Test 6: start while busy is ignored; stop+start in IDLE stays idle
        adv_base = adv_cnt2;
        st2 = 1'b1; tick(); st2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            st2 = 1'b1; tick(); st2 = 1'b0;
            strobe2();
            check($sformatf("t6_idx[%0d]", k), idx2, k);
            check($sformatf("t6_busy[%0d]", k), busy2, (k == 7) ? 0 : 1);
        end
        tick();
        check("t6_done", done2, 1);
        check("t6_len", adv_cnt2 - adv_base, 8);
        sp2 = 1'b1; st2 = 1'b1; tick(); sp2 = 1'b0; st2 = 1'b0;
        check("t6_stopstart_busy", busy2, 0);
        strobe2();
        check("t6_idle_adv", adv2, 0);
        check("t6_idle_busy", busy2, 0);

        // Test 3: w=0 ramp saturates from n=84
        st3 = 1'b1; tick(); st3 = 1'b0;
        for (int n = 0; n < 100; n++) begin
            a3 = 1'b1; tick(); a3 = 1'b0;
            e = (n <= 83) ? longint'(n) * 100000 : 8388607;
            check($sformatf("t3_out[%0d]", n), longint'(o3), e);
            tick();
        end
        check("t3_done", done3, 1);
        check("t3_busy", busy3, 0);

        // Test 4: full-scale tone against a truncating recurrence model
        c = 0;
        p = -3210181;
        peak = 0;
        st4 = 1'b1; tick(); st4 = 1'b0;
        for (int n = 0; n < 1024; n++) begin
            a4 = 1'b1; tick(); a4 = 1'b0;
            e = sat(c);
            samp4[n] = longint'(o4);
            diff = longint'(o4) - e;
            if (diff < 0) diff = -diff;
            check($sformatf("t4_within1[%0d]", n), (diff <= 1) ? 1 : 0, 1);
            if (samp4[n] > peak) peak = samp4[n];
            if (-samp4[n] > peak) peak = -samp4[n];
            q = (64'sd15500127 * c) / 64'sd8388608;
            q = q - p;
            p = c;
            c = q;
            tick();
        end
        check("t4_peak", (peak <= 8388607) ? 1 : 0, 1);
        check("t4_done", done4, 1);
        pk = gpower(64);
        pl = gpower(60);
        ph = gpower(68);
        check("t4_bin_vs_minus4", (pk > pl) ? 1 : 0, 1);
        check("t4_bin_vs_plus4", (pk > ph) ? 1 : 0, 1);

        check("adv_done_overlap", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
